// File: rtl/axi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_pkg
// Brief    : AXI4 burst/response encodings and the burst master state set.
// Revision : 1.0 - initial release
// ============================================================================
package axi_master_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AW    = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRESP = 3'd3,
        ST_AR    = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_master
// Brief    : Single-outstanding AXI4 initiator issuing one INCR burst per command.
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_master #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_ID_WIDTH  = 4,
    parameter int G_ADDRWIDTH = 32
) (
    input  logic                       s_aclk,
    input  logic                       s_aresetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rnw,
    input  logic [G_ADDRWIDTH-1:0]     cmd_addr,
    input  logic [7:0]                 cmd_len,
    input  logic [G_ID_WIDTH-1:0]      cmd_id,
    input  logic [G_DATAWIDTH-1:0]     wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [G_DATAWIDTH-1:0]     rd_data,
    output logic                       rd_valid,
    output logic                       rd_last,
    input  logic                       rd_ready,
    output logic                       done,
    output logic                       done_err,
    output logic [G_ID_WIDTH-1:0]      m_axi_awid,
    output logic [G_ADDRWIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [G_DATAWIDTH-1:0]     m_axi_wdata,
    output logic [G_DATAWIDTH/8-1:0]   m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [G_ID_WIDTH-1:0]      m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [G_ID_WIDTH-1:0]      m_axi_arid,
    output logic [G_ADDRWIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [G_ID_WIDTH-1:0]      m_axi_rid,
    input  logic [G_DATAWIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);
    import axi_master_pkg::*;

    localparam logic [2:0] c_SIZE = 3'($clog2(G_DATAWIDTH / 8));

    state_t                   r_state;
    logic [G_ADDRWIDTH-1:0]   r_addr;
    logic [7:0]               r_len;
    logic [G_ID_WIDTH-1:0]    r_id;
    logic [8:0]               r_cnt;
    logic                     r_err;
    logic                     r_cmd_ready;
    logic                     r_awvalid;
    logic                     r_arvalid;
    logic                     r_bready;
    logic                     r_done;
    logic                     r_done_err;

    logic w_in_wdata;
    logic w_in_rdata;
    logic w_at_last;
    logic w_wbeat;
    logic w_rbeat;
    logic w_rd_beat_err;
    logic w_unused;

    assign w_in_wdata = (r_state == ST_WDATA);
    assign w_in_rdata = (r_state == ST_RDATA);
    assign w_at_last  = (r_cnt == {1'b0, r_len});
    assign w_wbeat    = w_in_wdata && wr_valid && m_axi_wready;
    assign w_rbeat    = w_in_rdata && m_axi_rvalid && rd_ready;
    // A read beat is in error on SLVERR/DECERR, on rlast before the last
    // expected beat, or on the expected last beat arriving without rlast.
    assign w_rd_beat_err = m_axi_rresp[1]
                         | (m_axi_rlast && !w_at_last)
                         | (!m_axi_rlast && w_at_last);

    assign w_unused = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0]};

    assign cmd_ready     = r_cmd_ready;
    assign done          = r_done;
    assign done_err      = r_done_err;

    assign m_axi_awid    = r_id;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = c_SIZE;
    assign m_axi_awburst = c_BURST_INCR;
    assign m_axi_awvalid = r_awvalid;

    assign m_axi_arid    = r_id;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = c_SIZE;
    assign m_axi_arburst = c_BURST_INCR;
    assign m_axi_arvalid = r_arvalid;

    assign m_axi_bready  = r_bready;

    assign m_axi_wvalid  = w_in_wdata && wr_valid;
    assign wr_ready      = w_in_wdata && m_axi_wready;
    assign m_axi_wdata   = w_in_wdata ? wr_data : '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_in_wdata && w_at_last;

    assign m_axi_rready  = w_in_rdata && rd_ready;
    assign rd_valid      = w_in_rdata && m_axi_rvalid;
    assign rd_last       = w_in_rdata && m_axi_rlast;
    assign rd_data       = w_in_rdata ? m_axi_rdata : '0;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_done_err  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_addr      <= cmd_addr;
                        r_len       <= cmd_len;
                        r_id        <= cmd_id;
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        if (cmd_rnw) begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_wbeat) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (w_at_last) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (m_axi_bvalid) begin
                        r_bready   <= 1'b0;
                        r_err      <= r_err | m_axi_bresp[1];
                        r_done     <= 1'b1;
                        r_done_err <= r_err | m_axi_bresp[1];
                        r_state    <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (w_rbeat) begin
                        r_cnt <= r_cnt + 9'd1;
                        r_err <= r_err | w_rd_beat_err;
                        if (m_axi_rlast) begin
                            r_done     <= 1'b1;
                            r_done_err <= r_err | w_rd_beat_err;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
